// File: rtl/fetch_controller.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and fetch counter.
// Define FETCH_HALT_EN to stop fetching at end of memory instead of wrapping PC to 0.
module fetch_controller #(
    parameter int unsigned IMEM_BYTES = 160,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction_in,
    output logic [63:0] IFID_PC,
    output logic [31:0] IFID_Instruction,
    output logic        IFID_Valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [63:0] LAST_WORD = 64'(IMEM_BYTES - 4);
    localparam logic [31:0] NOP       = 32'h00000013;

    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_n;
    logic [63:0] pc, pc_n, ifid_pc_n;
    logic [31:0] instr_n, count_n;
    logic        valid_n;
    logic [63:0] br_pc, pc_plus4;

    assign br_pc        = {branch_target[63:2], 2'b00};
    assign pc_plus4     = pc + 64'd4;
    assign Inst_Address = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= RUN;
            pc               <= RESET_PC;
            IFID_PC          <= '0;
            IFID_Instruction <= NOP;
            IFID_Valid       <= 1'b0;
            fetch_count      <= '0;
        end else begin
            state            <= state_n;
            pc               <= pc_n;
            IFID_PC          <= ifid_pc_n;
            IFID_Instruction <= instr_n;
            IFID_Valid       <= valid_n;
            fetch_count      <= count_n;
        end
    end

    // Priority: redirect, then HALT/stall hold, then normal advance.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        ifid_pc_n = IFID_PC;
        instr_n   = IFID_Instruction;
        valid_n   = IFID_Valid;
        count_n   = fetch_count;
        if (branch_taken) begin
            pc_n    = br_pc;
            instr_n = NOP;
            valid_n = 1'b0;
`ifdef FETCH_HALT_EN
            if (state == HALT && br_pc > LAST_WORD) state_n = HALT;
            else                                    state_n = RUN;
`endif
        end else if (state == RUN && !stall) begin
`ifdef FETCH_HALT_EN
            if (pc > LAST_WORD) begin
                state_n = HALT;
                valid_n = 1'b0;
            end else begin
                ifid_pc_n = pc;
                instr_n   = Instruction_in;
                valid_n   = 1'b1;
                count_n   = fetch_count + 32'd1;
                pc_n      = pc_plus4;
            end
`else
            ifid_pc_n = pc;
            instr_n   = Instruction_in;
            valid_n   = 1'b1;
            count_n   = fetch_count + 32'd1;
            pc_n      = (pc_plus4 > LAST_WORD) ? '0 : pc_plus4;
`endif
        end
    end

`ifdef FETCH_HALT_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
